pool_window_gen: RTL and testbench
==================================

Name: pool_window_gen

Overview:
- Streaming producer for the pooling stage.
- Accepts one pixel per valid cycle in raster order and assembles non-overlapping NxN windows (stride N).
- Emits each window as one packed word in the exact layout the max_pooling block consumes on in_data.
- Sits between a conv/activation output stream and max_pooling; downstream is combinational, so one window word per out_valid pulse.

Parameters:
- N, 2, pooling window edge and stride; legal range 2..8.
- BitSize, 8, pixel width in bits; pixels are two's-complement signed.
- ImageWidth, 28, pixels per input row; must be a multiple of N (elaboration-time assertion).
- ImageHeight, 28, rows per frame; must be a multiple of N (elaboration-time assertion).

Ports:
- clk  input  1  rising-edge clock.
- res_n  input  1  asynchronous active-low reset.
- in_valid  input  1  in_data carries a pixel this cycle; no backpressure, so every valid pixel is consumed.
- in_data  input  BitSize  pixel value.
- out_valid  output  1  single-cycle pulse; out_data holds a complete window.
- out_data  output  BitSize*N*N  packed window; element r*N+c (window row r, column c) at bits [(r*N+c)*BitSize +: BitSize].
- out_last  output  1  asserted with out_valid on the final window of a frame.

Behaviour:
- Reset (res_n low, asynchronous): out_valid=0, out_last=0, out_data=0; all counters=0. Line-buffer contents are don't-care and are never emitted before being rewritten.
- Counters (advance only on in_valid):
  - col_cnt: 0..ImageWidth-1.
  - row_in_band: 0..N-1, increments when col_cnt wraps.
  - band_cnt: 0..ImageHeight/N-1, increments when row_in_band wraps.
  - All three wrap to 0 together after the last pixel of the frame; the next pixel starts a new frame with no idle cycle required.
- Storage:
  - N-1 line buffers of ImageWidth x BitSize, indexed by col_cnt.
  - Row r of a band (r < N-1) is written into buffer r.
  - Row N-1 is not stored. Its pixels go into an (N-1)-entry column shift register, cleared at each window's first column.
- Window completion: on an in_valid pixel with row_in_band==N-1 and col_cnt%N==N-1, the next clock edge registers out_data:
  - elements r<N-1 come from buffer r at columns col_cnt-N+1..col_cnt;
  - elements of row N-1 come from the shift register plus the current pixel.
- Latency: out_valid goes high exactly one cycle after the completing pixel is sampled and stays high for one cycle. out_data holds its value until the next window is registered.
- Throughput: at most one window per N input pixels. With continuous in_valid during row N-1 of a band, out_valid pulses every N cycles.
- out_last=1 iff the completing pixel is the last pixel of the frame (band_cnt, row_in_band, col_cnt all at maximum).
- in_valid gaps: allowed anywhere, including inside a window. Counters and buffers hold; output timing is relative to the completing pixel only.
- Reset mid-frame: the partial frame is discarded and no window is emitted for it. The first valid pixel after res_n deasserts is pixel (0,0) of a new frame.
- Simultaneous write/read on a line buffer: never occurs. Row N-1 reads buffers 0..N-2 and never writes them. Rows r<N-1 write only.
- Signedness: values pass through unchanged; no arithmetic is performed on pixel data.

Decomposition:
- Shared package pool_pkg:
  - localparams for the window element count (N*N) and the packed window width (BitSize*N*N);
  - a function win_idx(r,c) returning r*N+c, used by both this block and max_pooling benches.
- One natural sub-module: pool_line_buffer (single-port, synchronous-write, combinational-read array of ImageWidth x BitSize), instantiated N-1 times.

Test Plan:
- Basic 2x2 (N=2, W=H=4): continuous pixels 0..15.
  - -> out_valid one cycle after pixel 5, window {0,1,4,5} (elem0=0, elem1=1, elem2=4, elem3=5).
  - -> then {2,3,6,7} after pixel 7, {8,9,12,13}, and {10,11,14,15} with out_last=1.
  - -> exactly 4 pulses.
- Gapped input: same frame with in_valid toggling 1,0,0,1,... -> identical window contents; each pulse exactly one cycle after its completing pixel.
- N=3, W=H=6, pixels 0..35:
  - -> first window {0,1,2,6,7,8,12,13,14} one cycle after pixel 14;
  - -> 4 windows total, last {21,22,23,27,28,29,33,34,35} with out_last.
- Signed chain: pool_window_gen -> max_pooling, N=2, pixels of the first window -3,-1,-7,-2 (0xFD,0xFF,0xF9,0xFE).
  - -> max_pooling out_data receives packed elements exactly as listed.
  - -> max_pooling output = 0x00, because its internal max search is seeded with 0 and every element is negative.
  - -> an all-positive window {3,9,1,4} -> max_pooling output 9.
- Reset mid-frame: assert res_n low after pixel 9 of the 4x4 frame.
  - -> out_valid drops immediately (asynchronously).
  - -> after release, feeding 0..15 reproduces the Basic 2x2 results exactly.
- Back-to-back frames: two 4x4 frames with no gap -> 8 windows; out_last set on the 4th and 8th only.

Source files
------------

// File: rtl/pool_pkg.sv
// Shared definitions for the pooling stage: window geometry constants and the
// packed-window element index used by producers and consumers alike.
package pool_pkg;

    localparam int POOL_N        = 2;
    localparam int POOL_BIT_SIZE = 8;
    localparam int WIN_ELEMS     = POOL_N * POOL_N;
    localparam int WIN_WIDTH     = POOL_BIT_SIZE * WIN_ELEMS;

    // Element (r, c) of an n x n window sits at slot r*n+c of the packed word.
    function automatic int win_idx(input int r, input int c, input int n = POOL_N);
        return r * n + c;
    endfunction

endpackage

// File: rtl/pool_line_buffer.sv
// One image row of pixels: single shared address, synchronous write,
// combinational read.
module pool_line_buffer #(
    parameter  int Depth = 28,
    parameter  int Width = 8,
    localparam int AddrW = $clog2(Depth)
) (
    input  logic             clk,
    input  logic             i_we,
    input  logic [AddrW-1:0] i_addr,
    input  logic [Width-1:0] i_wdata,
    output logic [Width-1:0] o_rdata
);

    logic [Width-1:0] r_mem [Depth];

    // NOTE: the storage array has no reset; every entry is rewritten before it is read.
    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_addr] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[i_addr];

endmodule

// File: rtl/pool_window_gen.sv
// Assembles non-overlapping NxN windows (stride N) from a raster pixel stream
// and emits each as one packed word for the max-pooling stage.
module pool_window_gen
    import pool_pkg::*;
#(
    parameter int N           = POOL_N,
    parameter int BitSize     = POOL_BIT_SIZE,
    parameter int ImageWidth  = 28,
    parameter int ImageHeight = 28
) (
    input  logic                     clk,
    input  logic                     res_n,
    input  logic                     in_valid,
    input  logic [BitSize-1:0]       in_data,
    output logic                     out_valid,
    output logic [BitSize*N*N-1:0]   out_data,
    output logic                     out_last
);

    localparam int Bands = ImageHeight / N;
    localparam int CW    = $clog2(N);
    localparam int XW    = $clog2(ImageWidth);
    localparam int BW    = (Bands > 1) ? $clog2(Bands) : 1;

    if (N < 2 || N > 8) begin : g_bad_n
        $error("pool_window_gen: N must lie in 2..8");
    end
    if (ImageWidth % N != 0) begin : g_bad_width
        $error("pool_window_gen: ImageWidth must be a multiple of N");
    end
    if (ImageHeight % N != 0) begin : g_bad_height
        $error("pool_window_gen: ImageHeight must be a multiple of N");
    end

    logic [XW-1:0]              r_col_cnt;
    logic [CW-1:0]              r_col_in_win;
    logic [CW-1:0]              r_row_in_band;
    logic [BW-1:0]              r_band_cnt;
    logic [BitSize-1:0]         w_row_src [N];
    logic [BitSize-1:0]         r_stage   [N][N-1];
    logic [BitSize*N*N-1:0]     w_window;
    logic [BitSize*N*N-1:0]     r_out_data;
    logic                       r_out_valid;
    logic                       r_out_last;
    logic                       w_last_col;
    logic                       w_last_row;
    logic                       w_last_band;
    logic                       w_win_col_end;
    logic                       w_complete;
    logic                       w_frame_end;

    assign w_last_col    = (r_col_cnt == XW'(ImageWidth - 1));
    assign w_last_row    = (r_row_in_band == CW'(N - 1));
    assign w_last_band   = (r_band_cnt == BW'(Bands - 1));
    assign w_win_col_end = (r_col_in_win == CW'(N - 1));
    assign w_complete    = in_valid && w_last_row && w_win_col_end;
    assign w_frame_end   = w_last_band && w_last_row && w_last_col;

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge res_n) begin
        if (!res_n) begin
            r_col_cnt     <= '0;
            r_col_in_win  <= '0;
            r_row_in_band <= '0;
            r_band_cnt    <= '0;
        end else if (in_valid) begin
            r_col_in_win <= w_win_col_end ? '0 : r_col_in_win + 1'b1;
            if (w_last_col) begin
                r_col_cnt <= '0;
                if (w_last_row) begin
                    r_row_in_band <= '0;
                    r_band_cnt    <= w_last_band ? '0 : r_band_cnt + 1'b1;
                end else begin
                    r_row_in_band <= r_row_in_band + 1'b1;
                end
            end else begin
                r_col_cnt <= r_col_cnt + 1'b1;
            end
        end
    end

    // Rows 0..N-2 of a band live in line buffers; row N-1 streams straight from the input.
    for (genvar g = 0; g < N - 1; g++) begin : g_line
        logic w_we;
        assign w_we = in_valid && (r_row_in_band == CW'(g));

        pool_line_buffer #(
            .Depth (ImageWidth),
            .Width (BitSize)
        ) u_line_buffer (
            .clk     (clk),
            .i_we    (w_we),
            .i_addr  (r_col_cnt),
            .i_wdata (in_data),
            .o_rdata (w_row_src[g])
        );
    end
    assign w_row_src[N-1] = in_data;

    // During the last row of a band, the first N-1 columns of every window row are staged here.
    always_ff @(posedge clk) begin
        if (in_valid && w_last_row) begin
            for (int r = 0; r < N; r++) begin
                for (int c = 0; c < N - 1; c++) begin
                    if (r_col_in_win == CW'(c)) begin
                        r_stage[r][c] <= w_row_src[r];
                    end
                end
            end
        end
    end

    // NOTE: default assigned first so no path leaves w_window unassigned (no latch).
    always_comb begin
        w_window = '0;
        for (int r = 0; r < N; r++) begin
            for (int c = 0; c < N - 1; c++) begin
                w_window[win_idx(r, c, N)*BitSize +: BitSize] = r_stage[r][c];
            end
            w_window[win_idx(r, N - 1, N)*BitSize +: BitSize] = w_row_src[r];
        end
    end

    always_ff @(posedge clk or negedge res_n) begin
        if (!res_n) begin
            r_out_valid <= 1'b0;
            r_out_last  <= 1'b0;
            r_out_data  <= '0;
        end else begin
            r_out_valid <= w_complete;
            r_out_last  <= w_complete && w_frame_end;
            if (w_complete) begin
                r_out_data <= w_window;
            end
        end
    end

    assign out_valid = r_out_valid;
    assign out_last  = r_out_last;
    assign out_data  = r_out_data;

endmodule

// File: tb/tb_pool_window_gen.sv
// Self-checking bench for pool_window_gen: an image-array reference model,
// a per-cycle compare process and literal expectations for key windows.
module tb_pool_window_gen;
    import pool_pkg::*;

    typedef struct {
        int          due;
        logic [71:0] d;
        logic        last;
    } exp_t;

    logic                 clk;
    logic                 res_n;
    logic                 iv2, iv3;
    logic [7:0]           id2, id3;
    logic                 ov2, ov3, ol2, ol3;
    logic [WIN_WIDTH-1:0] od2;
    logic [71:0]          od3;

    int          tests;
    int          fails;
    int          cyc;
    exp_t        q0[$];
    exp_t        q1[$];
    logic [71:0] log_d0[$];
    logic [71:0] log_d1[$];
    logic        log_l0[$];
    logic        log_l1[$];
    logic [71:0] hold [2];
    int          pix_cnt [2];
    logic [7:0]  img [2][6][6];

    pool_window_gen #(.N(2), .BitSize(8), .ImageWidth(4), .ImageHeight(4)) dut2 (
        .clk(clk), .res_n(res_n), .in_valid(iv2), .in_data(id2),
        .out_valid(ov2), .out_data(od2), .out_last(ol2)
    );

    pool_window_gen #(.N(3), .BitSize(8), .ImageWidth(6), .ImageHeight(6)) dut3 (
        .clk(clk), .res_n(res_n), .in_valid(iv3), .in_data(id3),
        .out_valid(ov3), .out_data(od3), .out_last(ol3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    task automatic check(input string name, input logic [71:0] act, input logic [71:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Stand-in for the downstream max_pooling search: seeded with 0, signed compare.
    function automatic int maxpool2(input logic [71:0] w);
        int m;
        int v;
        m = 0;
        for (int i = 0; i < WIN_ELEMS; i++) begin
            v = int'($signed(w[i*8 +: 8]));
            if (v > m) m = v;
        end
        return m;
    endfunction

    // Place the pixel in the frame image; when it closes a window, expect that window next cycle.
    task automatic model_pixel(input int id, input logic [7:0] px);
        int   nn, w, k, row, col;
        exp_t e;
        nn  = (id == 0) ? 2 : 3;
        w   = (id == 0) ? 4 : 6;
        k   = pix_cnt[id];
        row = k / w;
        col = k % w;
        img[id][row][col] = px;
        if ((row % nn == nn - 1) && (col % nn == nn - 1)) begin
            e.due  = cyc + 1;
            e.d    = '0;
            e.last = (k == w * w - 1);
            for (int r = 0; r < nn; r++)
                for (int c = 0; c < nn; c++)
                    e.d[win_idx(r, c, nn)*8 +: 8] = img[id][row-nn+1+r][col-nn+1+c];
            if (id == 0) q0.push_back(e);
            else         q1.push_back(e);
        end
        pix_cnt[id] = (k + 1) % (w * w);
    endtask

    task automatic drive(input int id, input logic v, input logic [7:0] d);
        if (id == 0) begin iv2 = v; id2 = d; end
        else         begin iv3 = v; id3 = d; end
    endtask

    task automatic feed(input int id, input logic [7:0] px, input int gap);
        repeat (gap) begin
            @(negedge clk);
            drive(id, 1'b0, 8'($urandom));
        end
        @(negedge clk);
        drive(id, 1'b1, px);
        model_pixel(id, px);
    endtask

    task automatic idle(input int id, input int n);
        repeat (n) begin
            @(negedge clk);
            drive(id, 1'b0, 8'($urandom));
        end
    endtask

    task automatic compare_one(input int id, input logic ov, input logic [71:0] od, input logic ol);
        exp_t e;
        logic has;
        logic expv;
        if (!res_n) begin
            check($sformatf("reset_valid%0d", id), {71'b0, ov}, 72'd0);
            return;
        end
        has = (id == 0) ? (q0.size() > 0) : (q1.size() > 0);
        if (has) e = (id == 0) ? q0[0] : q1[0];
        expv = has && (e.due == cyc);
        check($sformatf("valid%0d@%0d", id, cyc), {71'b0, ov}, {71'b0, expv});
        if (expv) begin
            check($sformatf("data%0d@%0d", id, cyc), od, e.d);
            check($sformatf("last%0d@%0d", id, cyc), {71'b0, ol}, {71'b0, e.last});
            hold[id] = e.d;
            if (id == 0) void'(q0.pop_front());
            else         void'(q1.pop_front());
        end else begin
            check($sformatf("hold%0d@%0d", id, cyc), od, hold[id]);
        end
        if (ov) begin
            if (id == 0) begin log_d0.push_back(od); log_l0.push_back(ol); end
            else         begin log_d1.push_back(od); log_l1.push_back(ol); end
        end
    endtask

    always @(negedge clk) begin
        compare_one(0, ov2, {40'b0, od2}, ol2);
        compare_one(1, ov3, od3, ol3);
    end

    task automatic clear_logs();
        log_d0.delete(); log_l0.delete();
        log_d1.delete(); log_l1.delete();
    endtask

    task automatic do_reset();
        res_n = 1'b0;
        iv2 = 1'b0;
        iv3 = 1'b0;
        q0.delete();
        q1.delete();
        pix_cnt = '{0, 0};
        hold    = '{72'd0, 72'd0};
        #1;
        check("rst_valid2", {71'b0, ov2}, 72'd0);
        check("rst_last2",  {71'b0, ol2}, 72'd0);
        check("rst_data2",  {40'b0, od2}, 72'd0);
        check("rst_valid3", {71'b0, ov3}, 72'd0);
        check("rst_data3",  od3, 72'd0);
        repeat (2) @(negedge clk);
        #2 res_n = 1'b1;
    endtask

    task automatic check_basic_log(input string tag, input int base);
        logic [31:0] w [4];
        w = '{32'h05040100, 32'h07060302, 32'h0D0C0908, 32'h0F0E0B0A};
        for (int i = 0; i < 4; i++) begin
            check($sformatf("%s_win%0d", tag, i), log_d0[base+i], {40'b0, w[i]});
            check($sformatf("%s_last%0d", tag, i), {71'b0, log_l0[base+i]}, {71'b0, (i == 3)});
        end
    endtask

    initial begin
        logic [7:0] sp [16];
        int         gap;
        tests = 0;
        fails = 0;
        cyc   = 0;
        iv2 = 1'b0; iv3 = 1'b0; id2 = '0; id3 = '0;
        do_reset();

        clear_logs();
        for (int i = 0; i < 16; i++) feed(0, 8'(i), 0);
        idle(0, 3);
        check("basic_count", 72'(log_d0.size()), 72'd4);
        check_basic_log("basic", 0);

        clear_logs();
        for (int i = 0; i < 16; i++) feed(0, 8'(i), (i == 0) ? 0 : 2);
        idle(0, 3);
        check("gap_count", 72'(log_d0.size()), 72'd4);
        check_basic_log("gap", 0);

        clear_logs();
        for (int i = 0; i < 36; i++) feed(1, 8'(i), 0);
        idle(1, 3);
        check("n3_count", 72'(log_d1.size()), 72'd4);
        check("n3_first", log_d1[0], 72'h0E0D0C080706020100);
        check("n3_last_data", log_d1[3], 72'h2322211D1C1B171615);
        check("n3_last_flag", {71'b0, log_l1[3]}, 72'd1);
        check("n3_first_flag", {71'b0, log_l1[0]}, 72'd0);

        clear_logs();
        sp = '{8'hFD, 8'hFF, 8'h03, 8'h09, 8'hF9, 8'hFE, 8'h01, 8'h04,
               8'h11, 8'h80, 8'h7F, 8'h00, 8'h22, 8'hC0, 8'h05, 8'h06};
        for (int i = 0; i < 16; i++) feed(0, sp[i], 0);
        idle(0, 3);
        check("signed_win0", log_d0[0], 72'h00FEF9FFFD);
        check("signed_max0", 72'(maxpool2(log_d0[0])), 72'd0);
        check("signed_win1", log_d0[1], 72'h0004010903);
        check("signed_max1", 72'(maxpool2(log_d0[1])), 72'd9);

        for (int i = 0; i < 10; i++) feed(0, 8'(i), 0);
        @(posedge clk);
        #1 do_reset();
        clear_logs();
        for (int i = 0; i < 16; i++) feed(0, 8'(i), 0);
        idle(0, 3);
        check("rstmid_count", 72'(log_d0.size()), 72'd4);
        check_basic_log("rstmid", 0);

        clear_logs();
        for (int f = 0; f < 2; f++)
            for (int i = 0; i < 16; i++) feed(0, 8'(i), 0);
        idle(0, 3);
        check("b2b_count", 72'(log_d0.size()), 72'd8);
        check_basic_log("b2b_a", 0);
        check_basic_log("b2b_b", 4);

        for (int i = 0; i < 16; i++) feed(0, 8'(i), 0);
        @(posedge clk);
        #1;
        check("drop_pre_valid", {71'b0, ov2}, 72'd1);
        check("drop_pre_last",  {71'b0, ol2}, 72'd1);
        check("drop_pre_data",  {40'b0, od2}, 72'h000F0E0B0A);
        do_reset();

        clear_logs();
        fork
            begin
                for (int i = 0; i < 48; i++) begin
                    gap = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3)) : 0;
                    feed(0, 8'($urandom), gap);
                end
                idle(0, 4);
            end
            begin
                for (int i = 0; i < 72; i++) begin
                    gap = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3)) : 0;
                    feed(1, 8'($urandom), gap);
                end
                idle(1, 4);
            end
        join
        check("rand_count2", 72'(log_d0.size()), 72'd12);
        check("rand_count3", 72'(log_d1.size()), 72'd8);
        check("rand_pending2", 72'(q0.size()), 72'd0);
        check("rand_pending3", 72'(q1.size()), 72'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
